// File: rtl/bcd_serial_sub_ctrl_if.sv
// Operand/result bundle for the digit-serial BCD subtract controller.
// The requester side is master and the controller side is slave.
interface bcd_serial_sub_ctrl_if #(
    parameter int NDIGITS = 4
);
    logic                   start;
    logic [4*NDIGITS-1:0]   a;
    logic [4*NDIGITS-1:0]   b;
    logic                   busy;
    logic                   done;
    logic [4*NDIGITS-1:0]   diff;
    logic                   neg;
    logic                   err;

    modport master (
        output start, a, b,
        input  busy, done, diff, neg, err
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, neg, err
    );
endinterface

// File: rtl/bcd_serial_sub_ctrl.sv
// Digit-serial BCD subtractor sequencer: sign + magnitude of a-b, LSD first.
// Latency NDIGITS+1 (2*NDIGITS+1 if negative, 1 on bad digit); start ignored while busy.
module bcd_serial_sub_ctrl #(
    parameter int NDIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_serial_sub_ctrl_if.slave bus
);
    localparam int W  = 4 * NDIGITS;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

    state_t         state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   diff_q;
    logic [IW-1:0]  idx;
    logic           borrow;
    logic           busy_q;
    logic           done_q;
    logic           neg_q;
    logic           err_q;

    logic           bad_dig;
    logic [3:0]     op_x;
    logic [3:0]     op_y;
    logic [4:0]     t;
    logic [3:0]     dig;
    logic           last;

    always_comb begin
        bad_dig = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9)
                bad_dig = 1'b1;
        end
    end

    // One shared digit subtractor: a-b in SUB, 0-diff in NEG (10's complement).
    always_comb begin
        op_x = 4'd0;
        op_y = diff_q[4*int'(idx) +: 4];
        if (state == SUB) begin
            op_x = a_q[4*int'(idx) +: 4];
            op_y = b_q[4*int'(idx) +: 4];
        end
        t    = {1'b0, op_x} - {1'b0, op_y} - {4'd0, borrow};
        dig  = t[4] ? (t[3:0] + 4'd10) : t[3:0];
        last = (idx == IW'(NDIGITS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            neg_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        idx    <= '0;
                        borrow <= 1'b0;
                        diff_q <= '0;
                        neg_q  <= 1'b0;
                        if (bad_dig) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            err_q  <= 1'b0;
                            busy_q <= 1'b1;
                            state  <= SUB;
                        end
                    end
                end
                SUB, NEG: begin
                    diff_q[4*int'(idx) +: 4] <= dig;
                    if (last) begin
                        idx <= '0;
                        // A final borrow out of SUB means a<b: go form the magnitude.
                        if (state == SUB && t[4]) begin
                            borrow <= 1'b0;
                            state  <= NEG;
                        end else begin
                            borrow <= 1'b0;
                            neg_q  <= (state == NEG);
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end else begin
                        idx    <= idx + 1'b1;
                        borrow <= t[4];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.neg  = neg_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_serial_sub_ctrl.sv
// Directed-vector bench for bcd_serial_sub_ctrl at NDIGITS=4.
module tb_bcd_serial_sub_ctrl;
    localparam int ND = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    bcd_serial_sub_ctrl_if #(.NDIGITS(ND)) bus ();

    bcd_serial_sub_ctrl #(.NDIGITS(ND)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation; start is high for the accept edge only (cycle 0).
    // Cycle k is observed #1 after the k-th edge following the accept edge.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] exp_diff, input logic exp_neg,
                          input logic exp_err, input int exp_lat, input bit poke);
        int cyc;
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 1;
        chk({tag, "_busy"}, 32'(bus.busy), 32'(!exp_err));
        while (!bus.done && cyc < 40) begin
            if (poke && cyc == 2) begin
                bus.a     = 16'h9999;
                bus.b     = 16'h0000;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_lat"},  32'(cyc),      32'(exp_lat));
        chk({tag, "_diff"}, 32'(bus.diff), 32'(exp_diff));
        chk({tag, "_neg"},  32'(bus.neg),  32'(exp_neg));
        chk({tag, "_err"},  32'(bus.err),  32'(exp_err));
        chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_hold"},  32'(bus.diff), 32'(exp_diff));
    endtask

    initial begin
        int   k;
        logic saw;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_neg",  32'(bus.neg),  32'd0);
        chk("rst_err",  32'(bus.err),  32'd0);
        rst_n = 1'b1;
        @(posedge clk);

        run_op("t1",  16'h0048, 16'h0001, 16'h0047, 1'b0, 1'b0, 5, 1'b0);
        run_op("t2",  16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 5, 1'b0);
        run_op("t3",  16'h0001, 16'h0008, 16'h0007, 1'b1, 1'b0, 9, 1'b0);
        run_op("t4a", 16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 5, 1'b0);
        run_op("t4b", 16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 9, 1'b0);
        run_op("t5",  16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1, 1'b0);
        run_op("t5b", 16'h0012, 16'h000F, 16'h0000, 1'b0, 1'b1, 1, 1'b0);
        run_op("t7",  16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, 5, 1'b0);
        run_op("t8",  16'h0567, 16'h1234, 16'h0667, 1'b1, 1'b0, 9, 1'b0);
        run_op("t6",  16'h0048, 16'h0001, 16'h0047, 1'b0, 1'b0, 5, 1'b1);

        // Reset during cycle 3 of a negative-result run.
        @(negedge clk);
        bus.a     = 16'h0001;
        bus.b     = 16'h0008;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_diff", 32'(bus.diff), 32'd0);
        chk("mrst_neg",  32'(bus.neg),  32'd0);
        chk("mrst_err",  32'(bus.err),  32'd0);
        rst_n = 1'b1;
        saw = 1'b0;
        for (k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) saw = 1'b1;
        end
        chk("mrst_quiet", 32'(saw), 32'd0);

        run_op("post", 16'h0500, 16'h0250, 16'h0250, 1'b0, 1'b0, 5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
